// File: rtl/mux_2.sv
// rtl/mux_2.sv - 2:1 steering mux with registered copy, select-change detector and saturating switch counter (optional MUX_2_PARITY_EN adds parity_q)
module mux_2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q,
  output logic             sel_change,
  output logic [CNT_W-1:0] switch_count
`ifdef MUX_2_PARITY_EN
  ,
  output logic             parity_q
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A select edge is any cycle where the live select disagrees with last cycle's copy
  logic sel_diff;
  assign sel_diff = (sel != sel_q);

  // Pure combinational steering; the ternary merges A and B bitwise when sel is unknown
  always_comb begin
    Y = sel ? B : A;
  end

  // Registered copy of the output, select history and saturating switch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q          <= '0;
      sel_q        <= 1'b0;
      sel_change   <= 1'b0;
      switch_count <= '0;
    end else begin
      if (en) begin
        y_q <= Y;
      end
      sel_q      <= sel;
      sel_change <= sel_diff;
      if (sel_diff && (switch_count != CNT_MAX)) begin
        switch_count <= switch_count + 1'b1;
      end
    end
  end

`ifdef MUX_2_PARITY_EN
  // Parity of the selected word, captured alongside y_q
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (en) begin
      parity_q <= ^Y;
    end
  end
`endif

endmodule

// File: tb/tb_mux_2.sv
// tb/tb_mux_2.sv - self-checking bench for mux_2
module tb_mux_2;

  logic clk = 1'b0;
  logic rst, sel, en;
  logic A, B;
  logic Y, y_q, sel_q, sel_change;
  logic [7:0] switch_count;
  logic Y2, y_q2, sel_q2, sel_change2;
  logic [1:0] switch_count2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sbq[$];

  logic       m_yq, m_selq, m_chg;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;
  logic [7:0] tt = 8'b1101_1000;

  always #5 clk = ~clk;

  mux_2 #(.WIDTH(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel), .en(en),
    .Y(Y), .y_q(y_q), .sel_q(sel_q), .sel_change(sel_change),
    .switch_count(switch_count)
`ifdef MUX_2_PARITY_EN
    , .parity_q()
`endif
  );

  mux_2 #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel), .en(en),
    .Y(Y2), .y_q(y_q2), .sel_q(sel_q2), .sel_change(sel_change2),
    .switch_count(switch_count2)
`ifdef MUX_2_PARITY_EN
    , .parity_q()
`endif
  );

`ifdef MUX_2_PARITY_EN
  logic [3:0] A4, B4, Y4, y_q4;
  logic       sel_q4, chg4, par4;
  logic [7:0] cnt4;
  mux_2 #(.WIDTH(4), .CNT_W(8)) u_par (
    .clk(clk), .rst(rst), .A(A4), .B(B4), .sel(sel), .en(en),
    .Y(Y4), .y_q(y_q4), .sel_q(sel_q4), .sel_change(chg4),
    .switch_count(cnt4), .parity_q(par4)
  );
`endif

  function automatic logic [31:0] obs(int kind);
    case (kind)
      0:       return {31'b0, Y};
      1:       return {31'b0, y_q};
      2:       return {31'b0, sel_q};
      3:       return {31'b0, sel_change};
      4:       return {24'b0, switch_count};
      default: return {30'b0, switch_count2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] e, input string tag);
    sb_t it;
    it.kind = kind;
    it.exp  = e;
    it.tag  = tag;
    sbq.push_back(it);
  endtask

  task automatic drain();
    sb_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      check(it.tag, obs(it.kind), it.exp);
    end
  endtask

  // advance the reference model by one edge using the inputs currently driven
  task automatic clk_step(input string tag);
    if (rst) begin
      m_yq = 1'b0; m_selq = 1'b0; m_chg = 1'b0; m_cnt = '0; m_cnt2 = '0;
    end else begin
      if (en) m_yq = sel ? B : A;
      m_chg = (sel != m_selq);
      if (m_chg) begin
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      m_selq = sel;
    end
    push(1, {31'b0, m_yq},   {tag, ".y_q"});
    push(2, {31'b0, m_selq}, {tag, ".sel_q"});
    push(3, {31'b0, m_chg},  {tag, ".sel_change"});
    push(4, {24'b0, m_cnt},  {tag, ".count"});
    push(5, {30'b0, m_cnt2}, {tag, ".count_sat"});
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; A = 1'b0; B = 1'b0; sel = 1'b0;

    for (int i = 0; i < 8; i++) begin
      {A, B, sel} = i[2:0];
      #10;
      push(0, {31'b0, tt[i]}, $sformatf("truth%0d", i));
      drain();
    end

    sel = 1'bx; A = 1'b1; B = 1'b1;
    #1 push(0, 32'h1, "selx_match"); drain();
    A = 1'b0; B = 1'b1;
    #1 push(0, {31'b0, 1'bx}, "selx_differ"); drain();

    @(negedge clk);
    rst = 1'b1; A = 1'b1; B = 1'b0; sel = 1'b0; en = 1'b1;
    clk_step("rst1");
    clk_step("rst2");
    check("rst_y_q", {31'b0, y_q}, 32'h0);
    check("rst_Y", {31'b0, Y}, 32'h1);
    rst = 1'b0;
    clk_step("rel");
    check("rel_y_q", {31'b0, y_q}, 32'h1);

    A = 1'b0;
    clk_step("load0");
    en = 1'b0;
    A = 1'b1;
    #1 check("en0_Y", {31'b0, Y}, 32'h1);
    clk_step("hold");
    check("hold_y_q", {31'b0, y_q}, 32'h0);
    en = 1'b1;
    clk_step("en1");
    check("en1_y_q", {31'b0, y_q}, 32'h1);

    rst = 1'b1;
    clk_step("rst3");
    rst = 1'b0;
    sel = 1'b0; clk_step("seq0");
    sel = 1'b1; clk_step("seq1");
    check("seq1_chg", {31'b0, sel_change}, 32'h1);
    sel = 1'b1; clk_step("seq2");
    check("seq2_chg", {31'b0, sel_change}, 32'h0);
    sel = 1'b0; clk_step("seq3");
    sel = 1'b0; clk_step("seq4");
    check("seq_count", {24'b0, switch_count}, 32'd2);

    rst = 1'b1;
    clk_step("rst4");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sel = ~sel;
      clk_step($sformatf("tog%0d", i));
    end
    check("sat2_count", {30'b0, switch_count2}, 32'd3);
    check("tog_chg", {31'b0, sel_change}, 32'h1);
    for (int i = 6; i < 260; i++) begin
      sel = ~sel;
      clk_step($sformatf("tog%0d", i));
    end
    check("sat8_count", {24'b0, switch_count}, 32'd255);

    rst = 1'b1;
    clk_step("rst_mid");
    check("rst_mid_count", {24'b0, switch_count}, 32'd0);

    sel = 1'b1;
    clk_step("rst5");
    rst = 1'b0;
    clk_step("relsel1");
    check("relsel_chg", {31'b0, sel_change}, 32'h1);
    check("relsel_count", {24'b0, switch_count}, 32'd1);
    clk_step("relsel_next");
    check("relsel_next_chg", {31'b0, sel_change}, 32'h0);

`ifdef MUX_2_PARITY_EN
    A4 = 4'b1011; B4 = 4'b0000; sel = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check("parity_load", {31'b0, par4}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("parity_rst", {31'b0, par4}, 32'h0);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_2.md
Name: mux_2

Overview:
- 2:1 multiplexer with a combinational output Y (Y = A when sel=0, Y = B when sel=1).
- Adds a registered copy of the selected data, a select-change detector and a saturating switch counter for datapath steering and debug.
- Used as a leaf steering element wherever two sources share one sink.
- The combinational path does not depend on clk or rst.

Parameters:
- WIDTH, 1, bit width of A, B, Y and y_q.
- CNT_W, 8, width of the switch_count counter.

Ports:
- clk  input  1  rising-edge clock for all registered logic.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  data input selected when sel=0.
- B  input  WIDTH  data input selected when sel=1.
- sel  input  1  select (0 selects A, 1 selects B).
- en  input  1  register load enable for y_q.
- Y  output  WIDTH  combinational mux output.
- y_q  output  WIDTH  registered mux output.
- sel_q  output  1  registered copy of sel.
- sel_change  output  1  one-cycle pulse when sel differs from sel_q.
- switch_count  output  CNT_W  saturating count of select changes.

Behaviour:
- Combinational output
  - Y = sel ? B : A, purely combinational, zero latency, independent of clk, rst and en.
  - Y updates in the same delta as any change on A, B or sel.
  - All 8 single-bit combinations of A, B, sel follow the truth table: 000→0, 001→0, 010→0, 011→1, 100→1, 101→0, 110→1, 111→1 (order A,B,sel).
  - Unknown handling: if sel is X/Z, Y is X in bits where A and B differ and equals the common value in bits where they match.
- Registered outputs, on rising clk edge
  - If rst=1: y_q←0, sel_q←0, sel_change←0, switch_count←0. Reset has priority over en and over all other inputs.
  - Else y_q←Y when en=1, otherwise y_q holds its value. Latency is 1 cycle from the inputs to y_q.
  - Else sel_q←sel every cycle, regardless of en.
  - Else sel_change←(sel != sel_q). The pulse is high for exactly one cycle per transition; a sel toggling every cycle gives sel_change high continuously.
  - Else when sel differs from sel_q and switch_count is below its maximum, switch_count increments by 1.
  - switch_count saturates at 2^CNT_W-1 and never wraps.
- Reset cases
  - Reset mid-operation clears all registers on the next edge. Y is unaffected by reset.
  - The first cycle after reset compares sel against sel_q=0, so sel=1 at reset release produces one sel_change pulse and a count of 1.
- No internal state influences Y.

Optional Feature:
- Macro MUX_2_PARITY_EN.
- When defined:
  - Adds output port parity_q (1 bit).
  - On each clk edge with en=1, parity_q is loaded with the XOR reduction of Y. It holds when en=0 and resets to 0 on rst.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1, clk idle, rst=0: sweep all 8 combinations of A, B, sel with a 10 ns hold each → Y matches the truth table above, e.g. A=1,B=0,sel=1 gives Y=0 and A=0,B=1,sel=1 gives Y=1.
- rst=1 for 2 cycles with A=1, sel=0, en=1 → y_q=0, sel_q=0, switch_count=0 while Y=1. Release rst → y_q=1 after 1 edge.
- en=0, A toggles 0→1 with sel=0 → Y=1 immediately, y_q holds 0. Set en=1 → y_q=1 on the next edge.
- sel sequence 0,1,1,0,0 over 5 cycles → sel_change pulses on the cycles after each transition, and switch_count ends at 2.
- CNT_W=2: toggle sel every cycle for 6 cycles → switch_count reaches 3 and stays at 3.
- With MUX_2_PARITY_EN defined, WIDTH=4, A=4'b1011, sel=0, en=1 → parity_q=1 after 1 edge. Assert rst → parity_q=0.
